compensation_mem_ctrl: RTL and testbench
========================================

// Module: compensation_mem_ctrl
// PURPOSE
// - Sits directly downstream of the weight pre-processing unit. Captures its compensation
//   stream: 4b compensation weight, target row, and write address. Allocation is 3 slots
//   per column, addr = col*3 + slot.
// - On command, replays the whole compensation memory column by column into the
//   compensation PE path of the systolic array.
// - Tracks which slots hold live data, so empty slots are skipped as bubbles.
// PARAMETERS
// - SIZE                      8                      systolic array dimension (columns)
// - CMEM_SIZE                 SIZE*3                 compensation entries (3 per column)
// - CMEM_ADDR_WIDTH           $clog2(CMEM_SIZE)      write/read address width
// - CROW_WIDTH                $clog2(SIZE)           row index width
// - COMPENSATION_WEIGHT_WIDTH 4                      compensation weight width (sign + 3b)
// - CNT_WIDTH                 $clog2(CMEM_SIZE+1)    live-entry counter width
// PORTS
// - clk                       in   1           single clock, rising edge
// - rst                       in   1           synchronous, active-high reset
// - Compensation_out_valid    in   1           write strobe from upstream stage
// - Compensation_Weight       in   CW_WIDTH    compensation weight to store
// - Compensation_Row          in   CROW_WIDTH  row the weight applies to
// - Compensation_Mem_Wr_Addr  in   CMEM_ADDR   slot address
// - Clear                     in   1           invalidate all entries (honoured in IDLE only)
// - Load_Start                in   1           begin replay (honoured in IDLE only)
// - Comp_Strobe               out  1           one slot presented this cycle
// - Comp_Valid                out  1           presented slot holds live data
// - Comp_Weight               out  CW_WIDTH    weight; 0 when !Comp_Valid
// - Comp_Row                  out  CROW_WIDTH  row; 0 when !Comp_Valid
// - Comp_Col                  out  CROW_WIDTH  column of presented slot
// - Comp_Slot                 out  2           slot within column (0..2)
// - Load_Busy                 out  1           replay in progress
// - Load_Done                 out  1           one-cycle pulse, replay finished
// - Valid_Count               out  CNT_WIDTH   number of live entries
// BEHAVIOUR
// - Reset: all outputs 0, every valid bit 0, FSM = IDLE. Reset mid-replay aborts the
//   replay immediately; no Load_Done pulse.
// - Storage: CMEM_SIZE x {row, weight} plus one valid bit per entry.
// - Write path (any state):
//   - Valid && addr < CMEM_SIZE: store data and set the valid bit.
//   - Valid_Count += 1 only if the entry was previously invalid.
//   - Rewrite of a live entry overwrites data; count unchanged.
//   - addr >= CMEM_SIZE: ignored.
// - Clear (IDLE only): all valid bits 0, Valid_Count 0.
//   - Clear and write in the same cycle: Clear wins; the write is dropped.
//   - Clear while busy: ignored.
// - FSM IDLE -> READ -> DONE -> IDLE.
//   - IDLE: Load_Start -> READ, rd_addr = 0, Load_Busy = 1 from the next cycle.
//   - READ: rd_addr increments every cycle; after rd_addr = CMEM_SIZE-1 is issued -> DONE.
//   - DONE: Load_Done = 1 for one cycle, Load_Busy = 0 -> IDLE.
//   - Load_Start while not in IDLE: ignored.
// - Read latency is 1. Address issued in cycle t appears in cycle t+1 with Comp_Strobe = 1.
//   - Comp_Col = addr/3, Comp_Slot = addr%3.
//   - Slot k of the replay appears k+2 cycles after Load_Start (k = 0..CMEM_SIZE-1).
//   - Load_Done appears in the cycle after the last strobe.
// - Same-cycle write and read of one address: the read returns the OLD contents.
//   A write to a not-yet-read address during READ is visible when that slot is read.
// - Outputs are registered. Comp_Strobe and Comp_Valid are 0 outside replay data cycles.
// TESTING
// - Reset, then Load_Start: 24 strobes with Comp_Valid = 0, Col/Slot sequencing 0/0..7/2,
//   Load_Done at cycle 26; Valid_Count = 0.
// - Write addr 4 (w = 4'b1011, row = 5), addr 23 (w = 3, row = 7), then replay:
//   - strobe 4: Col 1, Slot 1, Valid = 1, W = 1011, Row = 5;
//   - strobe 23: Col 7, Slot 2, Valid = 1, W = 3, Row = 7;
//   - Valid_Count = 2.
// - Rewrite addr 4 with w = 2: Valid_Count stays 2, replay shows W = 2.
//   Write to addr 27: ignored, count unchanged.
// - Clear together with a write to addr 0 in IDLE: Valid_Count = 0, replay all invalid.
//   Clear during READ: ignored.
// - During READ, write addr 20 at the cycle rd_addr = 10: slot 20 replays the new data.
//   Write addr 10 in that same cycle: slot 10 shows the old data.
//   A second Load_Start mid-replay: ignored.
// - Assert rst at replay strobe 7: outputs 0 on the next cycle, no Load_Done, count 0.
//   A fresh Load_Start works normally.

Source files
------------

// File: rtl/compensation_mem_ctrl.sv
// Compensation memory controller.
// Captures the compensation stream from the weight pre-processing unit into a
// small table (3 slots per column, addr = col*3 + slot) with one live bit per
// entry. On Load_Start it replays every slot, column by column, into the
// compensation PE path; empty slots come out as bubbles (Comp_Valid = 0).
//
// Interface semantics: there is no back-pressure anywhere. An input write is
// taken in any cycle where Compensation_out_valid is high (no ready exists);
// Comp_Strobe marks a presented replay slot that the consumer must take in
// that same cycle. Load_Start and Clear are single-cycle requests that are
// only acted on while the controller is idle.
module compensation_mem_ctrl #(
  parameter int SIZE                      = 8,
  parameter int CMEM_SIZE                 = SIZE * 3,
  parameter int CMEM_ADDR_WIDTH           = $clog2(CMEM_SIZE),
  parameter int CROW_WIDTH                = $clog2(SIZE),
  parameter int COMPENSATION_WEIGHT_WIDTH = 4,
  parameter int CNT_WIDTH                 = $clog2(CMEM_SIZE + 1)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 Compensation_out_valid,
  input  logic [COMPENSATION_WEIGHT_WIDTH-1:0] Compensation_Weight,
  input  logic [CROW_WIDTH-1:0]                Compensation_Row,
  input  logic [CMEM_ADDR_WIDTH-1:0]           Compensation_Mem_Wr_Addr,
  input  logic                                 Clear,
  input  logic                                 Load_Start,
  output logic                                 Comp_Strobe,
  output logic                                 Comp_Valid,
  output logic [COMPENSATION_WEIGHT_WIDTH-1:0] Comp_Weight,
  output logic [CROW_WIDTH-1:0]                Comp_Row,
  output logic [CROW_WIDTH-1:0]                Comp_Col,
  output logic [1:0]                           Comp_Slot,
  output logic                                 Load_Busy,
  output logic                                 Load_Done,
  output logic [CNT_WIDTH-1:0]                 Valid_Count,
  output logic [1:0]                           dbg_state
);

  localparam int CW = COMPENSATION_WEIGHT_WIDTH;
  localparam int EW = CROW_WIDTH + CW;
  localparam logic [CMEM_ADDR_WIDTH:0]   ADDR_LIM = (CMEM_ADDR_WIDTH + 1)'(CMEM_SIZE);
  localparam logic [CMEM_ADDR_WIDTH-1:0] LAST_ADDR = CMEM_ADDR_WIDTH'(CMEM_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Storage: {row, weight} per entry plus a live bit per entry.
  logic [EW-1:0]              mem [CMEM_SIZE];
  logic [CMEM_SIZE-1:0]       valid_q;
  logic [CNT_WIDTH-1:0]       count_q;

  // Replay read pointer, with column/slot tracked alongside to avoid a divider.
  logic [CMEM_ADDR_WIDTH-1:0] rd_addr;
  logic [CROW_WIDTH-1:0]      rd_col;
  logic [1:0]                 rd_slot;

  logic                       clear_fire;
  logic                       wr_ok;
  logic [EW-1:0]              rd_entry;

  assign clear_fire = Clear && (state_q == IDLE);
  // Clear has priority over a coincident write; out-of-range addresses are dropped.
  assign wr_ok      = Compensation_out_valid && !clear_fire &&
                      ({1'b0, Compensation_Mem_Wr_Addr} < ADDR_LIM);
  assign rd_entry   = mem[rd_addr];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: one pass over every slot, then a single DONE cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (Load_Start) state_d = READ;
      READ:    if (rd_addr == LAST_ADDR) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read pointer walks 0..CMEM_SIZE-1 while in READ and sits at 0 otherwise.
  always_ff @(posedge clk) begin
    if (rst || state_q != READ || rd_addr == LAST_ADDR) begin
      rd_addr <= '0;
      rd_col  <= '0;
      rd_slot <= '0;
    end else begin
      rd_addr <= rd_addr + 1'b1;
      if (rd_slot == 2'd2) begin
        rd_slot <= 2'd0;
        rd_col  <= rd_col + 1'b1;
      end else begin
        rd_slot <= rd_slot + 1'b1;
      end
    end
  end

  // Data array write; contents are only meaningful where the live bit is set.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[Compensation_Mem_Wr_Addr] <= {Compensation_Row, Compensation_Weight};
  end

  // Live bits and live-entry count; a rewrite of a live entry leaves the count alone.
  always_ff @(posedge clk) begin
    if (rst || clear_fire) begin
      valid_q <= '0;
      count_q <= '0;
    end else if (wr_ok && !valid_q[Compensation_Mem_Wr_Addr]) begin
      valid_q[Compensation_Mem_Wr_Addr] <= 1'b1;
      count_q <= count_q + CNT_WIDTH'(1);
    end
  end

  // Registered replay outputs: the slot issued this cycle is presented next cycle,
  // so a write to the same address in the issuing cycle is not yet visible.
  always_ff @(posedge clk) begin
    if (rst || state_q != READ) begin
      Comp_Strobe <= 1'b0;
      Comp_Valid  <= 1'b0;
      Comp_Weight <= '0;
      Comp_Row    <= '0;
      Comp_Col    <= '0;
      Comp_Slot   <= '0;
    end else begin
      Comp_Strobe <= 1'b1;
      Comp_Valid  <= valid_q[rd_addr];
      Comp_Weight <= valid_q[rd_addr] ? rd_entry[CW-1:0] : '0;
      Comp_Row    <= valid_q[rd_addr] ? rd_entry[EW-1:CW] : '0;
      Comp_Col    <= rd_col;
      Comp_Slot   <= rd_slot;
    end
  end

  // Busy covers READ and DONE; Done pulses the cycle after the last strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      Load_Busy <= 1'b0;
      Load_Done <= 1'b0;
    end else begin
      Load_Busy <= (state_d != IDLE);
      Load_Done <= (state_q == DONE);
    end
  end

  assign Valid_Count = count_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_compensation_mem_ctrl.sv
// Testbench for compensation_mem_ctrl: directed scenarios followed by random
// traffic, with a table-level reference model and an expected-strobe queue.
module tb_compensation_mem_ctrl;

  localparam int CMEM  = 24;
  localparam int EXP_W = 29; // {display_cycle[15:0], col[2:0], slot[1:0], valid, weight[3:0], row[2:0]}

  logic       clk;
  logic       rst;
  logic       Compensation_out_valid;
  logic [3:0] Compensation_Weight;
  logic [2:0] Compensation_Row;
  logic [4:0] Compensation_Mem_Wr_Addr;
  logic       Clear;
  logic       Load_Start;
  logic       Comp_Strobe;
  logic       Comp_Valid;
  logic [3:0] Comp_Weight;
  logic [2:0] Comp_Row;
  logic [2:0] Comp_Col;
  logic [1:0] Comp_Slot;
  logic       Load_Busy;
  logic       Load_Done;
  logic [4:0] Valid_Count;
  logic [1:0] dbg_state;

  compensation_mem_ctrl dut (
    .clk                      (clk),
    .rst                      (rst),
    .Compensation_out_valid   (Compensation_out_valid),
    .Compensation_Weight      (Compensation_Weight),
    .Compensation_Row         (Compensation_Row),
    .Compensation_Mem_Wr_Addr (Compensation_Mem_Wr_Addr),
    .Clear                    (Clear),
    .Load_Start               (Load_Start),
    .Comp_Strobe              (Comp_Strobe),
    .Comp_Valid               (Comp_Valid),
    .Comp_Weight              (Comp_Weight),
    .Comp_Row                 (Comp_Row),
    .Comp_Col                 (Comp_Col),
    .Comp_Slot                (Comp_Slot),
    .Load_Busy                (Load_Busy),
    .Load_Done                (Load_Done),
    .Valid_Count              (Valid_Count),
    .dbg_state                (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  bit         m_v [CMEM];
  logic [3:0] m_w [CMEM];
  logic [2:0] m_r [CMEM];
  int         m_cnt    = 0;
  int         start    = 0;
  bit         start_ok = 1'b0;
  int         exp_vc   = 0;
  bit         exp_busy = 1'b0;
  bit         mon_en   = 1'b0;

  logic [EXP_W-1:0] exp_q[$];
  int               done_q[$];

  int checks = 0;
  int errors = 0;

  // A replay started in cycle s keeps the block busy in cycles s+1 .. s+25.
  function automatic bit busy_at(input int c);
    return start_ok && (c >= start + 1) && (c <= start + CMEM + 1);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < CMEM; i++) m_v[i] = 1'b0;
    m_cnt = 0;
  endtask

  // ---------------- driver ----------------
  // Applies one cycle of inputs and advances the model to the following edge.
  task automatic cycle(input bit rs, input bit wr, input int addr, input int w,
                       input int row, input bit clr, input bit ls);
    int k;
    logic [EXP_W-1:0] rec;
    logic [15:0] disp;
    rst                      = rs;
    Compensation_out_valid   = wr;
    Compensation_Mem_Wr_Addr = 5'(addr);
    Compensation_Weight      = 4'(w);
    Compensation_Row         = 3'(row);
    Clear                    = clr;
    Load_Start               = ls;
    exp_vc   = m_cnt;
    exp_busy = busy_at(cyc);
    if (rs) begin
      model_clear();
      start_ok = 1'b0;
      done_q.delete();
    end else begin
      // Slot k is read in cycle start+1+k and shown one cycle later, with the
      // table contents as they stand before this cycle's write lands.
      k = cyc - start - 1;
      if (start_ok && k >= 0 && k < CMEM) begin
        disp = 16'(cyc + 1);
        rec = {disp, 3'(k / 3), 2'(k % 3), m_v[k],
               m_v[k] ? m_w[k] : 4'd0, m_v[k] ? m_r[k] : 3'd0};
        exp_q.push_back(rec);
      end
      if (clr && !exp_busy) begin
        model_clear();
      end else if (wr && addr < CMEM) begin
        if (!m_v[addr]) m_cnt++;
        m_v[addr] = 1'b1;
        m_w[addr] = 4'(w);
        m_r[addr] = 3'(row);
      end
      if (ls && !exp_busy) begin
        start    = cyc;
        start_ok = 1'b1;
        done_q.push_back(cyc + CMEM + 2);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input int addr, input int w, input int row);
    cycle(0, 1, addr, w, row, 0, 0);
  endtask

  task automatic replay();
    cycle(0, 0, 0, 0, 0, 0, 1);
    idle(CMEM + 3);
  endtask

  // ---------------- scoreboard / monitor ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    bit exp_s;
    bit exp_d;
    if (mon_en) begin
      check("valid_count", 32'(Valid_Count), 32'(exp_vc));
      check("load_busy", 32'(Load_Busy), 32'(exp_busy));
      while (done_q.size() > 0 && done_q[0] < cyc) void'(done_q.pop_front());
      exp_d = (done_q.size() > 0 && done_q[0] == cyc);
      if (exp_d) void'(done_q.pop_front());
      check("load_done", 32'(Load_Done), 32'(exp_d));
      exp_s = (exp_q.size() > 0 && exp_q[0][28:13] == 16'(cyc));
      if (exp_s) begin
        e = exp_q.pop_front();
        check("comp_strobe", 32'(Comp_Strobe), 32'd1);
        check("comp_slot_data",
              32'({Comp_Col, Comp_Slot, Comp_Valid, Comp_Weight, Comp_Row}),
              32'(e[12:0]));
      end else begin
        check("idle_outputs", 32'({Comp_Strobe, Comp_Valid, Comp_Weight, Comp_Row}), 32'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int c0;
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    mon_en = 1'b1;

    // Empty table replay: all bubbles, done 26 cycles after the start.
    replay();

    // Two live entries.
    wr(4, 4'b1011, 5);
    wr(23, 3, 7);
    replay();

    // Rewrite of a live entry and an out-of-range write.
    wr(4, 2, 5);
    wr(27, 9, 1);
    replay();

    // Clear beats a coincident write, then a Clear during replay is ignored.
    cycle(0, 1, 0, 6, 2, 1, 0);
    replay();
    wr(1, 5, 3);
    wr(13, 7, 6);
    cycle(0, 0, 0, 0, 0, 0, 1);
    idle(5);
    cycle(0, 0, 0, 0, 0, 1, 0);
    idle(CMEM);

    // Write ahead of the read pointer shows up; write at the pointer does not.
    wr(10, 1, 1);
    wr(20, 2, 2);
    c0 = cyc;
    cycle(0, 0, 0, 0, 0, 0, 1);
    idle(10);
    cycle(0, 1, 20, 15, 4, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1);
    idle(CMEM);
    cycle(0, 0, 0, 0, 0, 0, 1);
    idle(10);
    cycle(0, 1, 10, 12, 6, 0, 0);
    idle(CMEM);
    replay();

    // Reset in the middle of a replay, then a fresh replay.
    cycle(0, 0, 0, 0, 0, 0, 1);
    idle(8);
    cycle(1, 0, 0, 0, 0, 0, 0);
    idle(2);
    wr(7, 3, 3);
    replay();

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 299) == 0,
            $urandom_range(0, 2) != 0,
            int'($urandom_range(0, 31)),
            int'($urandom_range(0, 15)),
            int'($urandom_range(0, 7)),
            $urandom_range(0, 39) == 0,
            $urandom_range(0, 11) == 0);
    end
    idle(CMEM + 4);

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("done_q_drained", 32'(done_q.size()), 32'd0);
    if (c0 < 0) $display("cycle origin %0d", c0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
